// File: rtl/obstacle_sequencer.sv
// -----------------------------------------------------------------------------
// obstacle_sequencer
//
// Game-flow controller for an obstacle-dodging game. It picks the next
// obstacle with an 8-bit LFSR (never repeating the previous code), launches it,
// waits for it to finish, idles for a gap, and repeats. While an obstacle is
// running it detects collisions between the obstacle's current pixel and the
// player box, applies a hit cooldown, and counts down lives to game over.
//
// Ports
//   clk               clock
//   rst               synchronous, active-high reset
//   start_i           level; starts a game from IDLE or restarts from OVER
//   obstacle_done_i   OR of every obstacle block's done pulse
//   obstacle_x_i/y_i  current obstacle pixel (0/0 = no pixel)
//   player_x_i/y_i    player box top-left corner
//   selected_o        obstacle code broadcast to all obstacle blocks
//   play_selected_o   enables the selected obstacle
//   obstacle_start_o  one-cycle launch pulse (obstacle done_in)
//   hit_o             one-cycle collision pulse
//   lives_o           remaining lives
//   game_over_o       high while the game is over
// -----------------------------------------------------------------------------
module obstacle_sequencer #(
  parameter int         NUM_OBSTACLES = 4,
  parameter int         GAP_CYCLES    = 64,
  parameter int         HIT_COOLDOWN  = 1024,
  parameter int         LIVES         = 3,
  parameter int         PLAYER_SIZE   = 20,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        obstacle_done_i,
  input  logic [11:0] obstacle_x_i,
  input  logic [11:0] obstacle_y_i,
  input  logic [11:0] player_x_i,
  input  logic [11:0] player_y_i,
  output logic [2:0]  selected_o,
  output logic        play_selected_o,
  output logic        obstacle_start_o,
  output logic        hit_o,
  output logic [1:0]  lives_o,
  output logic        game_over_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_LAUNCH,
    S_RUN,
    S_GAP,
    S_OVER
  } state_t;

  localparam int              CNT_W      = 21;
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(HIT_COOLDOWN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       sel_q, sel_d;
  logic             play_q, play_d;
  logic             launch_q, launch_d;
  logic             hit_q, hit_d;
  logic [1:0]       lives_q, lives_d;
  logic             over_q, over_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic [CNT_W-1:0] gap_q, gap_d;

  // Next LFSR value and the code it proposes.
  logic [7:0] lfsr_nx;
  logic [2:0] cand;
  logic       cand_ok;

  assign lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand    = lfsr_nx[2:0];
  assign cand_ok = (int'(cand) < NUM_OBSTACLES) &&
                   ((cand != last_q) || (NUM_OBSTACLES == 1));

  // Collision: compare in 13 bits so player + size cannot wrap past 4095.
  logic [12:0] ox_w, oy_w, px_w, py_w, px_end, py_end;
  logic        collide;
  logic        hit_ok;

  assign ox_w   = {1'b0, obstacle_x_i};
  assign oy_w   = {1'b0, obstacle_y_i};
  assign px_w   = {1'b0, player_x_i};
  assign py_w   = {1'b0, player_y_i};
  assign px_end = px_w + 13'(PLAYER_SIZE);
  assign py_end = py_w + 13'(PLAYER_SIZE);

  assign collide = ((obstacle_x_i | obstacle_y_i) != 12'd0) &&
                   (ox_w >= px_w) && (ox_w < px_end) &&
                   (oy_w >= py_w) && (oy_w < py_end);

  assign hit_ok = (state_q == S_RUN) && collide && (cool_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      last_q   <= 3'b111;
      sel_q    <= 3'b000;
      play_q   <= 1'b0;
      launch_q <= 1'b0;
      hit_q    <= 1'b0;
      lives_q  <= 2'd0;
      over_q   <= 1'b0;
      cool_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      play_q   <= play_d;
      launch_q <= launch_d;
      hit_q    <= hit_d;
      lives_q  <= lives_d;
      over_q   <= over_d;
      cool_q   <= cool_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    last_d   = last_q;
    sel_d    = sel_q;
    lives_d  = lives_q;
    gap_d    = gap_q;
    hit_d    = 1'b0;
    launch_d = 1'b0;
    // Cooldown runs down in every state, not only while an obstacle is live.
    cool_d   = (cool_q != '0) ? cool_q - CNT_W'(1) : cool_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lives_d = LIVES_INIT;
          cool_d  = '0;
          state_d = S_PICK;
        end
      end

      S_PICK: begin
        lfsr_d = lfsr_nx;
        if (cand_ok) begin
          sel_d    = cand;
          last_d   = cand;
          launch_d = 1'b1;
          state_d  = S_LAUNCH;
        end
      end

      S_LAUNCH: state_d = S_RUN;

      S_RUN: begin
        if (hit_ok) begin
          hit_d   = 1'b1;
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          // The hit cycle itself is part of the window, so the next hit can
          // land exactly HIT_COOLDOWN cycles after this one.
          cool_d  = COOL_LOAD;
        end
        // Losing the last life wins over a simultaneous obstacle_done.
        if (hit_ok && (lives_q <= 2'd1)) begin
          state_d = S_OVER;
        end else if (obstacle_done_i) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_PICK;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end

      S_OVER: begin
        lives_d = 2'd0;
        if (start_i) begin
          lives_d = LIVES_INIT;
          state_d = S_PICK;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    play_d = (state_d == S_LAUNCH) || (state_d == S_RUN);
    over_d = (state_d == S_OVER);
  end

  assign selected_o       = sel_q;
  assign play_selected_o  = play_q;
  assign obstacle_start_o = launch_q;
  assign hit_o            = hit_q;
  assign lives_o          = lives_q;
  assign game_over_o      = over_q;

endmodule

// File: tb/tb_obstacle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_obstacle_sequencer
//
// Self-checking bench for obstacle_sequencer. A behavioural model tracks the
// LFSR-driven code choice, lives, and the hit cooldown as "time since last
// hit"; scripted scenarios cover the launch/gap/hit/game-over flow, followed by
// a randomized play-through and a mid-run reset.
// -----------------------------------------------------------------------------
module tb_obstacle_sequencer;

  localparam int NUM  = 4;
  localparam int GAP  = 64;
  localparam int COOL = 1024;
  localparam int LIV  = 3;
  localparam int PS   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        obstacle_done;
  logic [11:0] obstacle_x, obstacle_y, player_x, player_y;
  logic [2:0]  selected_o;
  logic        play_selected_o, obstacle_start_o, hit_o, game_over_o;
  logic [1:0]  lives_o;

  obstacle_sequencer #(
    .NUM_OBSTACLES(NUM),
    .GAP_CYCLES   (GAP),
    .HIT_COOLDOWN (COOL),
    .LIVES        (LIV),
    .PLAYER_SIZE  (PS),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .obstacle_done_i (obstacle_done),
    .obstacle_x_i    (obstacle_x),
    .obstacle_y_i    (obstacle_y),
    .player_x_i      (player_x),
    .player_y_i      (player_y),
    .selected_o      (selected_o),
    .play_selected_o (play_selected_o),
    .obstacle_start_o(obstacle_start_o),
    .hit_o           (hit_o),
    .lives_o         (lives_o),
    .game_over_o     (game_over_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [7:0] m_lfsr;
  int         m_last;
  int         m_lives;
  int         m_last_hit;

  int code, steps, prev_code, bad;

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic bit model_collide(input int ox, input int oy, input int px, input int py);
    return (ox != 0 || oy != 0) && ox >= px && ox < px + PS && oy >= py && oy < py + PS;
  endfunction

  task automatic model_reset();
    m_lfsr     = 8'hA5;
    m_last     = 7;
    m_lives    = 0;
    m_last_hit = -1000000;
  endtask

  // Step the LFSR until a legal, non-repeating code appears.
  task automatic model_pick(output int c, output int n);
    c = -1;
    n = 0;
    while (c < 0 && n < 512) begin
      m_lfsr = lfsr_step(m_lfsr);
      n++;
      if (int'(m_lfsr[2:0]) < NUM && (int'(m_lfsr[2:0]) != m_last || NUM == 1)) begin
        c      = int'(m_lfsr[2:0]);
        m_last = c;
      end
    end
  endtask

  task automatic set_pos(input int ox, input int oy, input int px, input int py);
    obstacle_x = 12'(ox);
    obstacle_y = 12'(oy);
    player_x   = 12'(px);
    player_y   = 12'(py);
  endtask

  // One RUN cycle: drive inputs, take an edge, compare hit and lives.
  task automatic run_cycle(input int ox, input int oy, input int px, input int py,
                           input logic done, input string tag);
    bit eh;
    set_pos(ox, oy, px, py);
    obstacle_done = done;
    step();
    obstacle_done = 1'b0;
    eh = model_collide(ox, oy, px, py) && (cyc - m_last_hit >= COOL);
    if (eh) begin
      m_last_hit = cyc;
      if (m_lives > 0) m_lives--;
    end
    chk_eq({tag, "_hit"}, int'(hit_o), int'(eh));
    chk_eq({tag, "_lives"}, int'(lives_o), m_lives);
  endtask

  // Idle RUN cycles (no pixel) until the next edge index reaches target.
  task automatic idle_until(input int target, input string tag);
    int h = 0;
    set_pos(0, 0, 100, 100);
    while (cyc + 1 < target) begin
      step();
      if (hit_o) h++;
    end
    chk_eq({tag, "_idle_hits"}, h, 0);
  endtask

  // Count cycles with play_selected low until the launch, with a colliding
  // pixel present the whole time (must be ignored outside RUN).
  task automatic wait_launch(input int exp_low, input int exp_code, input string tag);
    int low = 0;
    int q   = 0;
    set_pos(110, 105, 100, 100);
    obstacle_done = 1'b0;
    while (play_selected_o == 1'b0 && low < exp_low + 200) begin
      if (low > 0 && (hit_o || obstacle_start_o)) q++;
      step();
      low++;
    end
    chk_eq({tag, "_low"}, low, exp_low);
    chk_eq({tag, "_start"}, int'(obstacle_start_o), 1);
    chk_eq({tag, "_sel"}, int'(selected_o), exp_code);
    chk_eq({tag, "_quiet"}, q, 0);
    step();
    chk_eq({tag, "_start_off"}, int'(obstacle_start_o), 0);
    chk_eq({tag, "_play"}, int'(play_selected_o), 1);
    chk_eq({tag, "_launch_nohit"}, int'(hit_o), 0);
    chk_eq({tag, "_sel_hold"}, int'(selected_o), exp_code);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_sel"}, int'(selected_o), 0);
    chk_eq({tag, "_play"}, int'(play_selected_o), 0);
    chk_eq({tag, "_start"}, int'(obstacle_start_o), 0);
    chk_eq({tag, "_hit"}, int'(hit_o), 0);
    chk_eq({tag, "_lives"}, int'(lives_o), 0);
    chk_eq({tag, "_over"}, int'(game_over_o), 0);
  endtask

  task automatic press_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    m_lives = LIV;
    chk_eq({tag, "_lives"}, int'(lives_o), LIV);
    chk_eq({tag, "_over"}, int'(game_over_o), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    obstacle_done = 1'b0;
    set_pos(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    step();
    step();
    chk_eq("idle_play", int'(play_selected_o), 0);

    // First game: seed gives code 2 after one PICK step.
    press_start("start0");
    model_pick(code, steps);
    wait_launch(steps, code, "L0");
    chk_eq("first_sel_is_2", int'(selected_o), 2);

    // Boundaries with cooldown clear.
    run_cycle(120, 100, 100, 100, 1'b0, "b_x120");
    run_cycle(100, 120, 100, 100, 1'b0, "b_y120");
    run_cycle(0, 0, 0, 0, 1'b0, "b_zero");

    // Pixel in the box for three cycles: one hit only.
    run_cycle(110, 105, 100, 100, 1'b0, "h3a");
    chk_eq("h3a_first", int'(hit_o), 1);
    run_cycle(110, 105, 100, 100, 1'b0, "h3b");
    run_cycle(110, 105, 100, 100, 1'b0, "h3c");
    chk_eq("h3_lives2", int'(lives_o), 2);

    // 1023 cycles later: blocked; 1024: hit on the far corner (119,119).
    idle_until(m_last_hit + COOL - 1, "cd1");
    run_cycle(110, 105, 100, 100, 1'b0, "c1023");
    chk_eq("c1023_nohit", int'(hit_o), 0);
    run_cycle(119, 119, 100, 100, 1'b0, "c1024");
    chk_eq("c1024_hit", int'(hit_o), 1);

    // Obstacle finishes: gap then a different code.
    prev_code = int'(selected_o);
    run_cycle(0, 0, 100, 100, 1'b1, "done1");
    chk_eq("done1_play_off", int'(play_selected_o), 0);
    model_pick(code, steps);
    wait_launch(GAP + steps, code, "G1");
    chk_eq("G1_new_code", int'(selected_o != 3'(prev_code)), 1);

    // Last life lost in the same cycle as obstacle_done: OVER, not GAP.
    idle_until(m_last_hit + COOL, "cd2");
    run_cycle(110, 105, 100, 100, 1'b1, "last");
    chk_eq("last_over", int'(game_over_o), 1);
    chk_eq("last_play", int'(play_selected_o), 0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (play_selected_o || obstacle_start_o || !game_over_o || lives_o != 2'd0) bad++;
    end
    chk_eq("over_stays", bad, 0);

    // Restart from OVER.
    press_start("restart");
    model_pick(code, steps);
    wait_launch(steps, code, "L2");

    // Randomized play until the game ends.
    for (int i = 0; i < 20000 && m_lives > 0; i++) begin
      int   ox, oy, px, py;
      logic dn;
      ox = $urandom_range(135, 95);
      oy = $urandom_range(135, 95);
      px = $urandom_range(110, 100);
      py = $urandom_range(110, 100);
      dn = ($urandom_range(15, 0) == 0);
      run_cycle(ox, oy, px, py, dn, "rnd");
      if (m_lives > 0 && dn) begin
        model_pick(code, steps);
        wait_launch(GAP + steps, code, "rgap");
      end
    end
    chk_eq("rnd_over", int'(game_over_o), 1);
    chk_eq("rnd_over_play", int'(play_selected_o), 0);

    // Reset in the middle of RUN, then replay from the seed.
    press_start("pre_rst");
    model_pick(code, steps);
    wait_launch(steps, code, "L3");
    run_cycle(0, 0, 100, 100, 1'b0, "pre_rst_run");
    set_pos(110, 105, 100, 100);
    obstacle_done = 1'b1;
    rst = 1'b1;
    step();
    obstacle_done = 1'b0;
    check_reset_outputs("midrst");
    rst = 1'b0;
    model_reset();
    step();
    press_start("replay");
    model_pick(code, steps);
    wait_launch(steps, code, "L4");
    chk_eq("replay_sel_is_2", int'(selected_o), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
